// File: rtl/dendy_pkg.sv
// Shared constants for the Dendy CPU-bus blocks.
// State encodings and register addresses used by the OAM DMA engine.
package dendy_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_WRITE = 2'd3;

   localparam logic [15:0] REG_OAMDMA  = 16'h4014;
   localparam logic [15:0] REG_OAMADDR = 16'h2003;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_WAIT  = S_WAIT,
      ST_READ  = S_READ,
      ST_WRITE = S_WRITE
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies one 256-byte PRG page into sprite memory
// while stalling the CPU.
module oam_dma
   import dendy_pkg::*;
#(
   parameter logic [15:0] DMA_REG      = REG_OAMDMA,
   parameter int          DUMMY_CYCLES = 1,
   parameter bit          ALIGN_ODD    = 1'b1
) (
   input  logic        clock25,
   input  logic        reset_n,
   input  logic        ce,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_o,
   input  logic        cpu_w,
   input  logic [7:0]  oam_base,
   input  logic [7:0]  dma_i,
   output logic [15:0] dma_a,
   output logic        dma_r,
   output logic [7:0]  oam_a,
   output logic [7:0]  oam_d,
   output logic        oam_w,
   output logic        cpu_halt,
   output logic        busy
);

   localparam logic [1:0] WAIT_INIT = 2'(DUMMY_CYCLES - 1);
   localparam logic       ALIGN     = ALIGN_ODD;

   dma_state_t state, state_nx;
   logic [7:0] page, page_nx;
   logic [7:0] idx, idx_nx;
   logic [7:0] base, base_nx;
   logic [1:0] wcnt, wcnt_nx;
   logic       parity;
   logic       trig;

   assign trig = cpu_w && (cpu_a == DMA_REG);

   always_ff @(posedge clock25) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         page   <= '0;
         idx    <= '0;
         base   <= '0;
         wcnt   <= '0;
         parity <= 1'b0;
      end else if (ce) begin
         state  <= state_nx;
         page   <= page_nx;
         idx    <= idx_nx;
         base   <= base_nx;
         wcnt   <= wcnt_nx;
         parity <= ~parity;
      end
   end

   always_comb begin
      state_nx = state;
      page_nx  = page;
      idx_nx   = idx;
      base_nx  = base;
      wcnt_nx  = wcnt;
      dma_a    = '0;
      dma_r    = 1'b0;
      oam_a    = '0;
      oam_d    = '0;
      oam_w    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (trig) begin
               page_nx  = cpu_o;
               idx_nx   = '0;
               base_nx  = oam_base;
               wcnt_nx  = WAIT_INIT + {1'b0, ALIGN & parity};
               state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wcnt == 2'd0) state_nx = ST_READ;
            else              wcnt_nx  = wcnt - 2'd1;
         end
         ST_READ: begin
            dma_a    = {page, idx};
            dma_r    = 1'b1;
            state_nx = ST_WRITE;
         end
         ST_WRITE: begin
            // Address stays on the bus so registered PRG data holds under slow ce.
            dma_a = {page, idx};
            oam_a = base + idx;
            oam_d = dma_i;
            oam_w = ce;
            if (idx == 8'hFF) begin
               state_nx = ST_IDLE;
            end else begin
               idx_nx   = idx + 8'd1;
               state_nx = ST_READ;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign cpu_halt = (state != ST_IDLE);
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a scoreboard of expected OAM writes.
// A second instance with ALIGN_ODD=0 checks the unaligned timing.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b1;
   logic [15:0] cpu_a = '0;
   logic [7:0]  cpu_o = '0;
   logic        cpu_w = 1'b0;
   logic [7:0]  oam_base = '0;
   logic [7:0]  dma_i = '0;
   logic [7:0]  dma_i2 = '0;
   logic [15:0] dma_a, dma_a2;
   logic        dma_r, dma_r2;
   logic [7:0]  oam_a, oam_a2, oam_d, oam_d2;
   logic        oam_w, oam_w2;
   logic        cpu_halt, halt2, busy, busy2;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  d;
      logic [15:0] src;
   } exp_t;

   exp_t sb[$];
   logic [7:0]  prg [0:4095];
   logic [7:0]  oam [0:255];
   logic [15:0] rd_addr = '0;
   int checks = 0;
   int failures = 0;
   int wcount = 0;
   int cyc = 0;
   int ce_div = 1;
   int ce_edges = 0;

   always #5 clk = ~clk;

   oam_dma dut (
      .clock25(clk), .reset_n(reset_n), .ce(ce),
      .cpu_a(cpu_a), .cpu_o(cpu_o), .cpu_w(cpu_w),
      .oam_base(oam_base), .dma_i(dma_i),
      .dma_a(dma_a), .dma_r(dma_r),
      .oam_a(oam_a), .oam_d(oam_d), .oam_w(oam_w),
      .cpu_halt(cpu_halt), .busy(busy)
   );

   oam_dma #(.ALIGN_ODD(1'b0)) dut2 (
      .clock25(clk), .reset_n(reset_n), .ce(ce),
      .cpu_a(cpu_a), .cpu_o(cpu_o), .cpu_w(cpu_w),
      .oam_base(oam_base), .dma_i(dma_i2),
      .dma_a(dma_a2), .dma_r(dma_r2),
      .oam_a(oam_a2), .oam_d(oam_d2), .oam_w(oam_w2),
      .cpu_halt(halt2), .busy(busy2)
   );

   // Registered PRG memory, one clock of read latency.
   always @(posedge clk) begin
      dma_i  <= prg[dma_a[11:0]];
      dma_i2 <= prg[dma_a2[11:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // OAM write monitor: values at negedge are those seen by the next posedge.
   always @(negedge clk) begin
      exp_t e;
      if (dma_r) rd_addr = dma_a;
      if (oam_w) begin
         chk("oam_w_needs_ce", {31'd0, ce}, 32'd1);
         chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("oam_a", {24'd0, oam_a}, {24'd0, e.a});
            chk("oam_d", {24'd0, oam_d}, {24'd0, e.d});
            chk("dma_a_src", {16'd0, dma_a}, {16'd0, e.src});
            chk("dma_a_hold", {16'd0, dma_a}, {16'd0, rd_addr});
         end
         oam[oam_a] = oam_d;
         wcount++;
      end
   end

   task automatic tick();
      if (!reset_n) ce_edges = 0;
      else if (ce) ce_edges++;
      @(posedge clk);
      #1;
      cyc++;
      ce = ((cyc % ce_div) == 0);
   endtask

   task automatic trigger(input logic [7:0] pg, input logic [7:0] bs,
                          input bit odd);
      int g;
      g = 0;
      while (!(ce && (ce_edges[0] == odd)) && g < 20) begin
         tick();
         g++;
      end
      chk("trigger_align", {31'd0, ce_edges[0]}, {31'd0, odd});
      for (int i = 0; i < 256; i++) begin
         exp_t e;
         e.a   = bs + 8'(i);
         e.d   = prg[{pg[3:0], 8'(i)}];
         e.src = {pg, 8'(i)};
         sb.push_back(e);
      end
      oam_base = bs;
      cpu_a = 16'h4014;
      cpu_o = pg;
      cpu_w = 1'b1;
      chk("halt_before", {31'd0, cpu_halt}, 32'd0);
      tick();
      cpu_w = 1'b0;
      cpu_a = 16'h0000;
   endtask

   task automatic run_full(input string tag, input int exp1, input int exp2);
      int n1, n2, g, w0;
      n1 = 0;
      n2 = 0;
      g = 0;
      w0 = wcount - 0;
      while ((cpu_halt || halt2) && g < 5000) begin
         if (cpu_halt) n1++;
         if (halt2) n2++;
         tick();
         g++;
      end
      chk({tag, "_timeout"}, {31'd0, g < 5000}, 32'd1);
      chk({tag, "_halt"}, n1, exp1);
      chk({tag, "_halt_noalign"}, n2, exp2);
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({tag, "_sb_drained"}, sb.size(), 32'd0);
   endtask

   initial begin
      int w0, g;
      for (int i = 0; i < 4096; i++) prg[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         prg[12'h200 + i] = 8'(i) ^ 8'h5A;
         prg[12'h300 + i] = 8'(i);
      end
      for (int i = 0; i < 256; i++) oam[i] = 8'hEE;

      tick();
      tick();
      chk("rst_halt", {31'd0, cpu_halt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_dma_r", {31'd0, dma_r}, 32'd0);
      chk("rst_oam_w", {31'd0, oam_w}, 32'd0);
      chk("rst_dma_a", {16'd0, dma_a}, 32'd0);
      chk("rst_oam_a", {24'd0, oam_a}, 32'd0);
      chk("rst_oam_d", {24'd0, oam_d}, 32'd0);
      reset_n = 1'b1;
      tick();

      w0 = wcount;
      trigger(8'h02, 8'h00, 1'b0);
      chk("busy_on", {31'd0, busy}, 32'd1);
      run_full("basic", 513, 513);
      chk("basic_writes", wcount - w0, 32'd256);
      chk("basic_oam0", {24'd0, oam[0]}, 32'h5A);
      chk("basic_oamff", {24'd0, oam[255]}, 32'hA5);

      trigger(8'h02, 8'h00, 1'b1);
      run_full("odd", 514, 513);

      trigger(8'h03, 8'hF0, 1'b0);
      oam_base = 8'h55;
      run_full("wrap", 513, 513);
      chk("wrap_f0", {24'd0, oam[8'hF0]}, 32'h00);
      chk("wrap_00", {24'd0, oam[8'h00]}, 32'h10);
      chk("wrap_ef", {24'd0, oam[8'hEF]}, 32'hFF);
      oam_base = 8'h00;

      ce_div = 3;
      w0 = wcount;
      trigger(8'h02, 8'h00, 1'b0);
      run_full("slow", 3 * 513, 3 * 513);
      chk("slow_writes", wcount - w0, 32'd256);
      chk("slow_oam7", {24'd0, oam[7]}, 32'h5D);

      ce_div = 1;
      tick();
      for (int i = 0; i < 256; i++) oam[i] = 8'hEE;
      w0 = wcount;
      trigger(8'h02, 8'h00, 1'b0);
      g = 0;
      while ((wcount - w0) < 100 && g < 1000) begin
         tick();
         g++;
      end
      chk("mid_timeout", {31'd0, g < 1000}, 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      sb.delete();
      chk("mid_halt", {31'd0, cpu_halt}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_oam_w", {31'd0, oam_w}, 32'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("mid_count", wcount - w0, 32'd100);
      chk("mid_oam99", {24'd0, oam[99]}, {24'd0, 8'd99 ^ 8'h5A});
      chk("mid_oam100", {24'd0, oam[100]}, 32'hEE);
      chk("mid_oamff", {24'd0, oam[255]}, 32'hEE);
      trigger(8'h02, 8'h00, 1'b0);
      run_full("after_rst", 513, 513);
      chk("after_oam100", {24'd0, oam[100]}, {24'd0, 8'd100 ^ 8'h5A});

      w0 = wcount;
      cpu_a = 16'h4013; cpu_o = 8'h02; cpu_w = 1'b1;
      tick();
      cpu_a = 16'h4015;
      tick();
      cpu_a = 16'h4014; cpu_w = 1'b0;
      tick();
      tick();
      chk("nt_halt", {31'd0, cpu_halt}, 32'd0);
      chk("nt_dma_r", {31'd0, dma_r}, 32'd0);
      cpu_a = 16'h0000;
      tick();
      tick();
      chk("nt_halt2", {31'd0, cpu_halt}, 32'd0);
      chk("nt_busy", {31'd0, busy}, 32'd0);
      chk("nt_writes", wcount - w0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
